// File: rtl/bit_stuff_pkg.sv
// Shared constants and FSM state type for the bit stuffing/destuffing engine.
package bit_stuff_pkg;

  localparam int MODE_STUFF   = 0;
  localparam int MODE_DESTUFF = 1;

  localparam int DEF_RUN_LEN = 5;
  localparam int DEF_CNT_W   = 13;

  typedef enum logic [1:0] {
    PASS,
    INSERT,
    DROP
  } state_e;

endpackage

// File: rtl/bit_stuff_engine_if.sv
// Serial bit stream handshake: upstream input channel plus downstream output channel.
interface bit_stuff_engine_if;

  logic in_valid;
  logic in_ready;
  logic in_bit;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic out_bit;
  logic out_last;

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_bit, out_last
  );

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_bit, out_last
  );

endinterface

// File: rtl/bit_stuff_outreg.sv
// One-entry valid/ready output register; the held bit stays stable until transferred.
module bit_stuff_outreg (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic bit_i,
  input  logic last_i,
  input  logic ready_i,
  output logic valid_o,
  output logic bit_o,
  output logic last_o,
  output logic free_o
);

  logic valid_q, valid_d;
  logic bit_q, bit_d;
  logic last_q, last_d;

  // The caller only loads when free_o is high, so a load never overwrites a held bit.
  assign free_o = !valid_q || ready_i;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    valid_d = valid_q;
    bit_d   = bit_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      bit_d   = bit_i;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign bit_o   = bit_q;
  assign last_o  = last_q;

endmodule

// File: rtl/bit_stuff_engine.sv
// Streaming bit stuffer (MODE=0) / destuffer (MODE=1), one bit per cycle, with
// per-frame event counter. frame_done and stuff_err are combinational pulses.
module bit_stuff_engine
  import bit_stuff_pkg::*;
#(
  parameter int   MODE      = MODE_STUFF,
  parameter int   RUN_LEN   = DEF_RUN_LEN,
  parameter logic STUFF_BIT = 1'b0,
  parameter int   CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  bit_stuff_engine_if.slave bus,
  output logic             frame_done,
  output logic             stuff_err,
  output logic [CNT_W-1:0] stuff_cnt
);

  localparam logic [3:0]       RUN_LAST = 4'(RUN_LEN - 1);
  localparam logic [3:0]       RUN_FULL = 4'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [CNT_W-1:0] live_q, live_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_pend_q, last_pend_d;

  logic             sync_clr;
  logic             slot_free;
  logic             accept;
  logic             run_hit;
  logic             load, load_bit, load_last;
  logic [CNT_W-1:0] live_inc;

  assign sync_clr     = rst || clr;
  assign bus.in_ready = !sync_clr && (state_q != INSERT) && slot_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign run_hit      = bus.in_bit && (run_q == RUN_LAST);
  assign live_inc     = (live_q == CNT_MAX) ? live_q : live_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    live_d      = live_q;
    cnt_d       = cnt_q;
    last_pend_d = last_pend_q;
    load        = 1'b0;
    load_bit    = bus.in_bit;
    load_last   = bus.in_last;
    frame_done  = 1'b0;
    stuff_err   = 1'b0;

    unique case (state_q)
      PASS: begin
        if (accept) begin
          load = 1'b1;
          if (run_hit) begin
            run_d = RUN_FULL;
            if (MODE == MODE_STUFF) begin
              // Frame end moves onto the stuffed bit that follows this one.
              state_d     = INSERT;
              last_pend_d = bus.in_last;
              load_last   = 1'b0;
            end else begin
              state_d = DROP;
            end
          end else begin
            run_d = bus.in_bit ? run_q + 4'd1 : 4'd0;
          end
          if (bus.in_last && !(run_hit && (MODE == MODE_STUFF))) begin
            frame_done = 1'b1;
            cnt_d      = live_q;
            live_d     = '0;
            run_d      = 4'd0;
            state_d    = PASS;
          end
        end
      end

      INSERT: begin
        if (slot_free && !sync_clr) begin
          load        = 1'b1;
          load_bit    = STUFF_BIT;
          load_last   = last_pend_q;
          run_d       = 4'd0;
          live_d      = live_inc;
          last_pend_d = 1'b0;
          state_d     = PASS;
          if (last_pend_q) begin
            frame_done = 1'b1;
            cnt_d      = live_inc;
            live_d     = '0;
          end
        end
      end

      DROP: begin
        if (accept) begin
          run_d     = 4'd0;
          live_d    = live_inc;
          stuff_err = (bus.in_bit != STUFF_BIT);
          state_d   = PASS;
          if (bus.in_last) begin
            frame_done = 1'b1;
            cnt_d      = live_inc;
            live_d     = '0;
          end
        end
      end

      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_clr) begin
      state_q     <= PASS;
      run_q       <= 4'd0;
      live_q      <= '0;
      cnt_q       <= '0;
      last_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      live_q      <= live_d;
      cnt_q       <= cnt_d;
      last_pend_q <= last_pend_d;
    end
  end

  bit_stuff_outreg u_outreg (
    .clk     (clk),
    .rst     (sync_clr),
    .load_i  (load),
    .bit_i   (load_bit),
    .last_i  (load_last),
    .ready_i (bus.out_ready),
    .valid_o (bus.out_valid),
    .bit_o   (bus.out_bit),
    .last_o  (bus.out_last),
    .free_o  (slot_free)
  );

  assign stuff_cnt = cnt_q;

endmodule

// File: tb/tb_bit_stuff_engine.sv
// Directed bench for bit_stuff_engine: four parameterisations share one muxed driver.
module tb_bit_stuff_engine;
  import bit_stuff_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       tb_clr = 1'b0;
  logic       tb_in_valid = 1'b0, tb_in_bit = 1'b0, tb_in_last = 1'b0;
  logic       tb_out_ready = 1'b1;
  logic       rand_ready = 1'b0;
  logic [1:0] sel = 2'd0;

  int n_checks = 0;
  int n_fail   = 0;

  // sel: 0 stuff/5, 1 destuff/5, 2 stuff/3, 3 stuff/5 with 2-bit counter
  bit_stuff_engine_if if_s5 ();
  bit_stuff_engine_if if_d5 ();
  bit_stuff_engine_if if_s3 ();
  bit_stuff_engine_if if_c2 ();

  assign if_s5.in_valid = tb_in_valid && (sel == 2'd0);
  assign if_d5.in_valid = tb_in_valid && (sel == 2'd1);
  assign if_s3.in_valid = tb_in_valid && (sel == 2'd2);
  assign if_c2.in_valid = tb_in_valid && (sel == 2'd3);
  assign if_s5.in_bit = tb_in_bit;  assign if_s5.in_last = tb_in_last;  assign if_s5.out_ready = tb_out_ready;
  assign if_d5.in_bit = tb_in_bit;  assign if_d5.in_last = tb_in_last;  assign if_d5.out_ready = tb_out_ready;
  assign if_s3.in_bit = tb_in_bit;  assign if_s3.in_last = tb_in_last;  assign if_s3.out_ready = tb_out_ready;
  assign if_c2.in_bit = tb_in_bit;  assign if_c2.in_last = tb_in_last;  assign if_c2.out_ready = tb_out_ready;

  logic        fd0, fd1, fd2, fd3, er0, er1, er2, er3;
  logic [12:0] cnt0, cnt1, cnt2;
  logic [1:0]  cnt3;

  bit_stuff_engine #(.MODE(MODE_STUFF), .RUN_LEN(5), .STUFF_BIT(1'b0), .CNT_W(13)) u_s5 (
    .clk(clk), .rst(rst), .clr(tb_clr), .bus(if_s5), .frame_done(fd0), .stuff_err(er0), .stuff_cnt(cnt0));
  bit_stuff_engine #(.MODE(MODE_DESTUFF), .RUN_LEN(5), .STUFF_BIT(1'b0), .CNT_W(13)) u_d5 (
    .clk(clk), .rst(rst), .clr(tb_clr), .bus(if_d5), .frame_done(fd1), .stuff_err(er1), .stuff_cnt(cnt1));
  bit_stuff_engine #(.MODE(MODE_STUFF), .RUN_LEN(3), .STUFF_BIT(1'b0), .CNT_W(13)) u_s3 (
    .clk(clk), .rst(rst), .clr(tb_clr), .bus(if_s3), .frame_done(fd2), .stuff_err(er2), .stuff_cnt(cnt2));
  bit_stuff_engine #(.MODE(MODE_STUFF), .RUN_LEN(5), .STUFF_BIT(1'b0), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .clr(tb_clr), .bus(if_c2), .frame_done(fd3), .stuff_err(er3), .stuff_cnt(cnt3));

  logic        m_in_ready, m_out_valid, m_out_bit, m_out_last, m_frame_done, m_stuff_err;
  logic [12:0] m_stuff_cnt;

  always_comb begin
    m_in_ready = if_s5.in_ready;  m_out_valid = if_s5.out_valid;
    m_out_bit  = if_s5.out_bit;   m_out_last  = if_s5.out_last;
    m_frame_done = fd0;  m_stuff_err = er0;  m_stuff_cnt = cnt0;
    case (sel)
      2'd1: begin
        m_in_ready = if_d5.in_ready;  m_out_valid = if_d5.out_valid;
        m_out_bit  = if_d5.out_bit;   m_out_last  = if_d5.out_last;
        m_frame_done = fd1;  m_stuff_err = er1;  m_stuff_cnt = cnt1;
      end
      2'd2: begin
        m_in_ready = if_s3.in_ready;  m_out_valid = if_s3.out_valid;
        m_out_bit  = if_s3.out_bit;   m_out_last  = if_s3.out_last;
        m_frame_done = fd2;  m_stuff_err = er2;  m_stuff_cnt = cnt2;
      end
      2'd3: begin
        m_in_ready = if_c2.in_ready;  m_out_valid = if_c2.out_valid;
        m_out_bit  = if_c2.out_bit;   m_out_last  = if_c2.out_last;
        m_frame_done = fd3;  m_stuff_err = er3;  m_stuff_cnt = 13'(cnt3);
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: collects transferred bits and counts pulses; all counters only grow.
  logic out_q[$];
  logic last_q[$];
  int   acc_cnt = 0, fd_cnt = 0, fd_at = 0, err_cnt = 0, err_at = 0, lowrdy_cnt = 0;

  initial begin : monitor
    logic       hold_pending = 1'b0;
    logic       hold_bit = 1'b0, hold_last = 1'b0;
    logic [1:0] hold_sel = 2'd0;
    forever begin
      @(negedge clk);
      if (hold_pending && (sel == hold_sel)) begin
        check("hold_valid", 64'(m_out_valid), 64'd1);
        check("hold_bit", 64'(m_out_bit), 64'(hold_bit));
        check("hold_last", 64'(m_out_last), 64'(hold_last));
      end
      hold_pending = m_out_valid && !tb_out_ready && !tb_clr && !rst;
      hold_bit  = m_out_bit;
      hold_last = m_out_last;
      hold_sel  = sel;
      if (!rst && m_out_valid && tb_out_ready) begin
        out_q.push_back(m_out_bit);
        last_q.push_back(m_out_last);
      end
      if (tb_in_valid && m_in_ready) acc_cnt++;
      if (m_frame_done) begin fd_cnt++; fd_at = acc_cnt; end
      if (m_stuff_err) begin err_cnt++; err_at = acc_cnt; end
      if (!rst && !tb_clr && !m_in_ready) lowrdy_cnt++;
    end
  end

  initial begin : random_ready
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) tb_out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b, input logic last);
    int waited = 0;
    tb_in_valid = 1'b1;
    tb_in_bit   = b;
    tb_in_last  = last;
    @(negedge clk);
    while (!m_in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!m_in_ready) check("in_accept_timeout", 64'(m_in_ready), 64'd1);
    @(posedge clk);
    #1;
    tb_in_valid = 1'b0;
    tb_in_last  = 1'b0;
  endtask

  task automatic send_vec(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], i == 0);
  endtask

  task automatic drain(input int target, input int bound);
    int w = 0;
    while (out_q.size() < target && w < bound) begin
      @(posedge clk);
      w++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack(input int base, input int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++)
      r = {r[62:0], (base + i < out_q.size()) ? out_q[base + i] : 1'b0};
    return r;
  endfunction

  function automatic int count_last(input int base);
    int c = 0;
    for (int i = base; i < last_q.size(); i++) if (last_q[i]) c++;
    return c;
  endfunction

  localparam logic [63:0] RAW25  = 64'b1111100011111010111011111;
  localparam logic [63:0] STUF28 = 64'b1111100001111100101110111110;

  initial begin : main
    int b, f, a, e, lr, n_exp, n_stuff, run;
    logic in_bits[$];
    logic exp_bits[$];

    // Reset state of every instance
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      #1;
      check("rst_in_ready", 64'(m_in_ready), 64'd0);
      check("rst_out_valid", 64'(m_out_valid), 64'd0);
      check("rst_stuff_cnt", 64'(m_stuff_cnt), 64'd0);
      check("rst_frame_done", 64'(m_frame_done), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    sel = 2'd0;

    // 1: stuff, 25-bit frame, ready always high
    b = out_q.size(); f = fd_cnt; lr = lowrdy_cnt;
    send_vec(RAW25, 25);
    drain(b + 28, 100);
    check("t1_len", 64'(out_q.size() - b), 64'd28);
    check("t1_bits", pack(b, 28), STUF28);
    check("t1_last_cnt", 64'(count_last(b)), 64'd1);
    check("t1_last_pos", 64'(last_q[b + 27]), 64'd1);
    check("t1_in_ready_low", 64'(lowrdy_cnt - lr), 64'd3);
    check("t1_frame_done", 64'(fd_cnt - f), 64'd1);
    check("t1_stuff_cnt", 64'(m_stuff_cnt), 64'd3);

    // 2: destuff the stuffed stream back
    sel = 2'd1;
    b = out_q.size(); f = fd_cnt; a = acc_cnt; e = err_cnt;
    send_vec(STUF28, 28);
    drain(b + 25, 100);
    check("t2_len", 64'(out_q.size() - b), 64'd25);
    check("t2_bits", pack(b, 25), RAW25);
    check("t2_last_cnt", 64'(count_last(b)), 64'd0);
    check("t2_stuff_err", 64'(err_cnt - e), 64'd0);
    check("t2_frame_done", 64'(fd_cnt - f), 64'd1);
    check("t2_fd_on_bit", 64'(fd_at - a), 64'd28);
    check("t2_stuff_cnt", 64'(m_stuff_cnt), 64'd3);

    // 3: destuff with a bad stuff bit
    b = out_q.size(); f = fd_cnt; a = acc_cnt; e = err_cnt;
    send_vec(64'b1111110, 7);
    drain(b + 6, 100);
    check("t3_stuff_err", 64'(err_cnt - e), 64'd1);
    check("t3_err_on_bit", 64'(err_at - a), 64'd6);
    check("t3_len", 64'(out_q.size() - b), 64'd6);
    check("t3_bits", pack(b, 6), 64'b111110);
    check("t3_last_cnt", 64'(count_last(b)), 64'd1);
    check("t3_frame_done", 64'(fd_cnt - f), 64'd1);
    check("t3_stuff_cnt", 64'(m_stuff_cnt), 64'd1);

    // 4: stuff 1000 random bits with random backpressure
    sel = 2'd0;
    b = out_q.size(); f = fd_cnt;
    run = 0; n_stuff = 0;
    for (int i = 0; i < 1000; i++) begin
      in_bits.push_back(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      exp_bits.push_back(in_bits[i]);
      run = in_bits[i] ? run + 1 : 0;
      if (run == 5) begin
        exp_bits.push_back(1'b0);
        run = 0;
        n_stuff++;
      end
    end
    n_exp = exp_bits.size();
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) send_bit(in_bits[i], i == 999);
    drain(b + n_exp, 3000);
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    tb_out_ready = 1'b1;
    check("t4_len", 64'(out_q.size() - b), 64'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      check("t4_bit", 64'(out_q[b + i]), 64'(exp_bits[i]));
      check("t4_last", 64'(last_q[b + i]), 64'(i == n_exp - 1));
    end
    check("t4_frame_done", 64'(fd_cnt - f), 64'd1);
    check("t4_stuff_cnt", 64'(m_stuff_cnt), 64'(n_stuff));

    // 5: RUN_LEN=3, clr in mid-frame while the 4th bit is held
    sel = 2'd2;
    repeat (3) send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    tb_out_ready = 1'b0;
    tb_clr = 1'b1;
    @(posedge clk);
    #1;
    tb_clr = 1'b0;
    @(negedge clk);
    check("t5_clr_out_valid", 64'(m_out_valid), 64'd0);
    @(posedge clk);
    #1;
    tb_out_ready = 1'b1;
    b = out_q.size(); f = fd_cnt;
    send_vec(64'b111, 3);
    drain(b + 4, 100);
    check("t5_len", 64'(out_q.size() - b), 64'd4);
    check("t5_bits", pack(b, 4), 64'b1110);
    check("t5_last_pos", 64'(last_q[b + 3]), 64'd1);
    check("t5_frame_done", 64'(fd_cnt - f), 64'd1);
    check("t5_stuff_cnt", 64'(m_stuff_cnt), 64'd1);

    // 6: 2-bit counter saturation over eight stuff events
    sel = 2'd3;
    b = out_q.size(); f = fd_cnt;
    for (int i = 0; i < 40; i++) send_bit(1'b1, i == 39);
    drain(b + 48, 200);
    check("t6_len", 64'(out_q.size() - b), 64'd48);
    check("t6_last_cnt", 64'(count_last(b)), 64'd1);
    check("t6_frame_done", 64'(fd_cnt - f), 64'd1);
    check("t6_stuff_cnt", 64'(m_stuff_cnt), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
